// File: rtl/serial_adder_seq_if.sv
// Handshake and operand/result bundle for serial_adder_seq.
// The slave modport is the adder's view; master is the requester's view.
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_s;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_start, i_a, i_b, i_sub, i_cin,
    input  o_busy, o_done, o_s, o_cout, o_ovf
  );

  modport slave (
    input  i_start, i_a, i_b, i_sub, i_cin,
    output o_busy, o_done, o_s, o_cout, o_ovf
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry.
// Operands shift right; each chunk of sum bits enters the partial result from the top.
module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_seq_if.slave bus
);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_adder_seq: CHUNK must divide WIDTH exactly and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK:0]   w_sum;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  // Carry into the chunk's top bit is recovered from that bit's sum and inputs.
  always_comb begin
    w_sum      = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    w_c_msb    = w_sum[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
    w_acc_next = r_acc >> CHUNK;
    w_acc_next[WIDTH-1 -: CHUNK] = w_sum[CHUNK-1:0];
    w_last     = (r_cnt == CW'(STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_sub | bus.i_cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_acc   <= w_acc_next;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_s     <= w_acc_next;
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= w_c_msb ^ w_sum[CHUNK];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_s    = r_s;
  assign bus.o_cout = r_cout;
  assign bus.o_ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: four WIDTH=8 instances (CHUNK 1,2,4,8) and one WIDTH=4/CHUNK=2,
// checked every cycle against an arithmetic model of the operation schedule and results.
module tb_serial_adder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;

  logic       busy_o [5];
  logic       done_o [5];
  logic [7:0] s_o    [5];
  logic       cout_o [5];
  logic       ovf_o  [5];

  for (genvar g = 0; g < 4; g++) begin : g_w8
    serial_adder_seq_if #(.WIDTH(8)) bus ();
    assign bus.i_start = start8;
    assign bus.i_a     = a8;
    assign bus.i_b     = b8;
    assign bus.i_sub   = sub8;
    assign bus.i_cin   = cin8;
    serial_adder_seq #(.WIDTH(8), .CHUNK(1 << g)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    assign busy_o[g] = bus.o_busy;
    assign done_o[g] = bus.o_done;
    assign s_o[g]    = bus.o_s;
    assign cout_o[g] = bus.o_cout;
    assign ovf_o[g]  = bus.o_ovf;
  end

  serial_adder_seq_if #(.WIDTH(4)) bus4 ();
  assign bus4.i_start = start4;
  assign bus4.i_a     = a4;
  assign bus4.i_b     = b4;
  assign bus4.i_sub   = sub4;
  assign bus4.i_cin   = cin4;
  serial_adder_seq #(.WIDTH(4), .CHUNK(2)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  assign busy_o[4] = bus4.o_busy;
  assign done_o[4] = bus4.o_done;
  assign s_o[4]    = {4'h0, bus4.o_s};
  assign cout_o[4] = bus4.o_cout;
  assign ovf_o[4]  = bus4.o_ovf;

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, inst, got, want, $time);
  endtask

  // Result {ovf, cout, s[7:0]} from plain signed/unsigned arithmetic.
  function automatic logic [9:0] golden(input int w, input int a, input int b,
                                        input bit sub, input bit cin);
    int mask, half, full, sa, sb, sr;
    logic [9:0] r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    if (sub) begin
      full = a + ((~b) & mask) + 1;
      sr   = sa - sb;
    end else begin
      full = a + b + int'(cin);
      sr   = sa + sb + int'(cin);
    end
    r[7:0] = 8'(full & mask);
    r[8]   = 1'((full >> w) & 1);
    r[9]   = (sr > half - 1) || (sr < -half);
    return r;
  endfunction

  int         steps  [5] = '{8, 4, 2, 1, 2};
  int         widths [5] = '{8, 8, 8, 8, 4};
  int         m_rem  [5] = '{0, 0, 0, 0, 0};
  bit         m_done [5] = '{0, 0, 0, 0, 0};
  logic [9:0] m_out  [5] = '{0, 0, 0, 0, 0};
  logic [9:0] m_pend [5] = '{0, 0, 0, 0, 0};

  // Model: an accepted start schedules a result STEPS edges later; start while running is dropped.
  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      bit st, sb, ci;
      int a, b;
      if (k < 4) begin st = start8; a = int'(a8); b = int'(b8); sb = sub8; ci = cin8; end
      else       begin st = start4; a = int'(a4); b = int'(b4); sb = sub4; ci = cin4; end
      if (rst) begin
        m_rem[k] = 0; m_done[k] = 0; m_out[k] = '0;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
        m_done[k] = 0;
        if (m_rem[k] == 0) begin m_done[k] = 1; m_out[k] = m_pend[k]; end
      end else begin
        m_done[k] = 0;
        if (st) begin m_rem[k] = steps[k]; m_pend[k] = golden(widths[k], a, b, sb, ci); end
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 5; k++) begin
        check("busy", k, 32'(busy_o[k]), 32'(m_rem[k] > 0));
        check("done", k, 32'(done_o[k]), 32'(m_done[k]));
        check("s",    k, 32'(s_o[k]),    32'(m_out[k][7:0]));
        check("cout", k, 32'(cout_o[k]), 32'(m_out[k][8]));
        check("ovf",  k, 32'(ovf_o[k]),  32'(m_out[k][9]));
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit cin);
    a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Called at the negedge after a start edge; counts edges until done on the CHUNK=1 instance.
  task automatic wait_done8(input string name, input int want_lat, input logic [9:0] want_res);
    int n;
    n = 0;
    while (done_o[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, 0, 32'(n), 32'(want_lat));
    check({name, "_res"}, 0, {22'd0, ovf_o[0], cout_o[0], s_o[0]}, 32'(want_res));
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    while ((busy_o[0] | busy_o[1] | busy_o[2] | busy_o[3] |
            done_o[0] | done_o[1] | done_o[2] | done_o[3]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 0, 32'(n < 50), 32'd1);
  endtask

  initial begin
    int ndone, n;
    check("gold_5a33", 0, 32'(golden(8, 'h5A, 'h33, 0, 0)), 32'({1'b1, 1'b0, 8'h8D}));
    check("gold_ff01", 0, 32'(golden(8, 'hFF, 'h01, 0, 0)), 32'({1'b0, 1'b1, 8'h00}));
    check("gold_0f00", 0, 32'(golden(8, 'h0F, 'h00, 0, 1)), 32'({1'b0, 1'b0, 8'h10}));
    check("gold_0507", 0, 32'(golden(8, 'h05, 'h07, 1, 1)), 32'({1'b0, 1'b0, 8'hFE}));
    check("gold_8001", 0, 32'(golden(8, 'h80, 'h01, 1, 1)), 32'({1'b1, 1'b1, 8'h7F}));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s", 0, 32'(s_o[0]), 32'd0);
    check("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    drive8(8'h5A, 8'h33, 0, 0);
    check("busy_after_start", 0, 32'(busy_o[0]), 32'd1);
    wait_done8("add_5a33", 8, {1'b1, 1'b0, 8'h8D});
    wait_idle8();
    drive8(8'hFF, 8'h01, 0, 0);
    wait_done8("add_ff01", 8, {1'b0, 1'b1, 8'h00});
    wait_idle8();
    drive8(8'h0F, 8'h00, 0, 1);
    wait_done8("add_cin", 8, {1'b0, 1'b0, 8'h10});
    wait_idle8();
    drive8(8'h05, 8'h07, 1, 1);
    wait_done8("sub_0507", 8, {1'b0, 1'b0, 8'hFE});
    wait_idle8();
    drive8(8'h80, 8'h01, 1, 1);
    wait_done8("sub_8001", 8, {1'b1, 1'b1, 8'h7F});
    wait_idle8();

    // start while busy is ignored; start in the DONE cycle runs back-to-back
    drive8(8'h11, 8'h22, 0, 0);
    repeat (2) @(negedge clk);
    drive8(8'hF0, 8'hF0, 1, 1);
    wait_done8("ignored_start", 5, {1'b0, 1'b0, 8'h33});
    drive8(8'h40, 8'h01, 1, 0);
    check("b2b_busy", 0, 32'(busy_o[0]), 32'd1);
    wait_done8("b2b", 8, {1'b0, 1'b1, 8'h3F});
    wait_idle8();

    // abort mid-run
    drive8(8'hAA, 8'h55, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 0, 32'(busy_o[0]), 32'd0);
    check("abort_done", 0, 32'(done_o[0]), 32'd0);
    check("abort_s", 0, 32'(s_o[0]), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    check("abort_no_done", 0, 32'(ndone), 32'd0);

    // random traffic on the WIDTH=8 instances, including starts while busy and rare resets
    for (int i = 0; i < 2000; i++) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      sub8   = 1'($urandom);
      cin8   = 1'($urandom);
      rst    = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    start8 = 1'b0;
    rst    = 1'b0;
    wait_idle8();

    // exhaustive WIDTH=4, issued back-to-back in each DONE cycle
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int m = 0; m < 4; m++) begin
          a4 = 4'(a); b4 = 4'(b); sub4 = m[1]; cin4 = m[0]; start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (done_o[4] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
          end
          check("w4_lat", 4, 32'(n), 32'd2);
        end
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the single-bit combinational half adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock using a registered carry, with start/busy/done handshake.
- Intended for area-constrained datapaths in the course designs where a full-width ripple adder is not wanted; also the reusable arithmetic block for the next labs.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CHUNK, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request new operation; accepted only when busy=0
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- sub  input  1  0: a+b+cin, 1: a-b (cin ignored), sampled on accepted start
- cin  input  1  carry in for add mode, sampled on accepted start
- busy  output  1  high while operation in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- s  output  WIDTH  result, registered
- cout  output  1  carry out (sub mode: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: one clock, synchronous, active-high; rst has priority over everything. State IDLE; busy=0, done=0, s=0, cout=0, ovf=0; operand shift registers, step counter and carry cleared.
- Reset mid-operation aborts: no done pulse; the in-flight result is lost.
- Internal constant STEPS = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch a; latch b (sub=1: latch ~b); initial carry = sub ? 1 : cin. Clear counter, go to RUN, busy=1 from the next cycle.
- RUN: each edge adds CHUNK LSBs of both operand registers plus carry. Shift the operand registers right by CHUNK. Shift the CHUNK sum bits into the top of the partial-result register; update carry; increment counter.
- On the edge completing step STEPS:
  - Write s = partial result and cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB; track carry into the MSB within the last chunk.
  - Go to DONE with done=1, busy=0.
- Latency: start sampled at edge E0; done=1 in the cycle following edge E(STEPS). WIDTH=8, CHUNK=1 gives 8 cycles; CHUNK=WIDTH gives 1 cycle.
- DONE lasts exactly one cycle, then IDLE; done returns to 0.
- start=1 during DONE is accepted as in IDLE, giving back-to-back operation; busy=1 the next cycle.
- start while busy=1 is ignored; operand and mode changes are ignored.
- s/cout/ovf change only at the edge entering DONE and hold until the next completion or reset.
- Arithmetic modulo 2^WIDTH. Sub mode computes a + ~b + 1; cout=0 means borrow (a<b unsigned).

Test Plan:
- Reset then WIDTH=8,CHUNK=1: a=8'h5A, b=8'h33, sub=0, cin=0 -> done exactly 8 cycles after start edge, s=8'h8D, cout=0, ovf=1; busy high for 8 cycles.
- Add carry/cin: 8'hFF+8'h01, cin=0 -> s=8'h00, cout=1, ovf=0. 8'h0F+8'h00, cin=1 -> s=8'h10, cout=0, ovf=0.
- Subtract: 8'h05-8'h07 -> s=8'hFE, cout=0, ovf=0. 8'h80-8'h01 -> s=8'h7F, cout=1, ovf=1. cin=1 is ignored in both.
- Handshake: start pulsed while busy with different operands -> ignored, first result unchanged. start asserted in the DONE cycle -> second op runs, busy=1 next cycle, second done 8 cycles later.
- rst asserted mid-RUN (cycle 4) -> next cycle busy=0, done=0, s=0; no done pulse ever for the aborted op.
- Parameter sweep WIDTH=8 with CHUNK in {1,2,4,8}, exhaustive 4-bit (WIDTH=4) check of all a,b,sub,cin against a golden model -> all results match; latency = WIDTH/CHUNK.
